ltz_edge_catch: RTL
===================

LTZ_EDGE_CATCH -- requirements
Module: ltz_edge_catch

Interface
REQ-001 Parameter FILTER, default 4: number of consecutive cycles sin must differ from level before level changes; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of evt_cnt; legal range 1..32.
REQ-003 Parameter INITVAL, default 1'b0: reset value of level.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sin  input  1  level already synchronized into clk domain by the upstream two-flop stage.
REQ-007 rise_en  input  1  rising-edge events enabled.
REQ-008 fall_en  input  1  falling-edge events enabled.
REQ-009 evt_ready  input  1  consumer accepts the event.
REQ-010 ovf_clr  input  1  clears evt_ovf.
REQ-011 level  output  1  filtered level.
REQ-012 evt_valid  output  1  event held for consumer.
REQ-013 evt_rise  output  1  held event polarity; 1 = rising, 0 = falling.
REQ-014 evt_ovf  output  1  sticky flag: an event was dropped.
REQ-015 evt_cnt  output  CNT_W  count of accepted events.

Function
REQ-016 Filter FSM SHALL have two states: STABLE (sin == level, qual counter 0) and QUALIFY (sin != level, counting).
REQ-017 In STABLE, sin != level SHALL move to QUALIFY with qual counter = 1.
REQ-018 In QUALIFY, sin == level SHALL return to STABLE and clear the counter; no level change, no event.
REQ-019 When sin != level on the cycle the counter reaches FILTER, level SHALL toggle at that edge and the FSM SHALL return to STABLE; FILTER=1 gives level = sin delayed by 1 cycle.
REQ-020 The qual counter SHALL be 8 bits wide and SHALL never exceed FILTER.
REQ-021 A level toggle 0->1 with rise_en=1, or 1->0 with fall_en=1, SHALL generate an event at the same clock edge that updates level.
REQ-022 Event buffer is one entry: a generated event SHALL load evt_valid=1 and evt_rise=new level when the buffer is empty or is being accepted (evt_valid & evt_ready) in that cycle.
REQ-023 A generated event while evt_valid=1 and evt_ready=0 SHALL be dropped, leaving the held event unchanged, and SHALL set evt_ovf.
REQ-024 evt_valid & evt_ready with no new event SHALL clear evt_valid at the next edge.
REQ-025 evt_valid and evt_rise SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-026 ovf_clr=1 SHALL clear evt_ovf; a drop in the same cycle SHALL take priority, leaving evt_ovf=1.
REQ-027 evt_cnt SHALL increment by 1 on each cycle with evt_valid & evt_ready and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 Deasserting rise_en or fall_en SHALL NOT cancel an event already held.

Reset
REQ-029 rst_n low SHALL immediately set level=INITVAL, FSM=STABLE, qual counter=0, evt_valid=0, evt_rise=0, evt_ovf=0 and evt_cnt=0.
REQ-030 Reset asserted mid-qualification or with an event pending SHALL discard both, with no event generated on release.
REQ-031 After release, an sin value differing from INITVAL SHALL qualify normally and produce an event if enabled.

Configuration
REQ-032 Macro LTZ_EDGE_CATCH_CNT_EN defined: evt_cnt SHALL be implemented per REQ-027.
REQ-033 Macro LTZ_EDGE_CATCH_CNT_EN undefined: evt_cnt SHALL be constant 0 with no counter register; all other behaviour SHALL be unchanged.

Verification
REQ-034 FILTER=4, rise_en=1, sin 0->1 held for 4 cycles -> level=1 and evt_valid=1, evt_rise=1 at the 4th edge after sin rises.
REQ-035 FILTER=4, sin high for 3 cycles then low -> level stays 0, evt_valid stays 0.
REQ-036 evt_ready=0, two qualified edges -> first event held, second dropped, evt_ovf=1; ovf_clr=1 -> evt_ovf=0 next cycle.
REQ-037 evt_valid=1 and a new event arrive in the same cycle as evt_ready=1 -> new event loaded, evt_ovf stays 0, evt_cnt +1.
REQ-038 CNT_W=2, 5 accepted events -> evt_cnt sequence 1,2,3,0,1; with the macro undefined -> evt_cnt always 0.
REQ-039 rst_n pulsed low during QUALIFY with evt_valid=1 -> all outputs at reset values; no event follows release while sin == INITVAL.

Source files
------------

// File: rtl/ltz_edge_catch.sv
// Edge detector with a glitch filter and a one-entry event buffer that sets a sticky overflow flag on drops.
// Optional accepted-event counter is enabled by defining LTZ_EDGE_CATCH_CNT_EN.
module ltz_edge_catch #(
  parameter int   FILTER  = 4,
  parameter int   CNT_W   = 8,
  parameter logic INITVAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             level,
  output logic             evt_valid,
  output logic             evt_rise,
  output logic             evt_ovf,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [7:0] FILTER_C = 8'(FILTER);

  state_t     state_r;
  logic [7:0] qual_r;
  logic       level_r;
  logic       evt_valid_r;
  logic       evt_rise_r;
  logic       evt_ovf_r;

  logic [7:0] qual_nxt_s;
  logic       toggle_s;
  logic       gen_s;
  logic       accept_s;
  logic       load_s;
  logic       drop_s;

  // Qualification count and event/handshake decisions for this cycle
  always_comb begin
    qual_nxt_s = 8'd0;
    toggle_s   = 1'b0;
    if (sin != level_r) begin
      if (state_r == QUALIFY) begin
        qual_nxt_s = qual_r + 8'd1;
      end else begin
        qual_nxt_s = 8'd1;
      end
      toggle_s = (qual_nxt_s == FILTER_C);
    end else begin
      qual_nxt_s = 8'd0;
      toggle_s   = 1'b0;
    end
    gen_s    = toggle_s & ((~level_r & rise_en) | (level_r & fall_en));
    accept_s = evt_valid_r & evt_ready;
    load_s   = gen_s & (~evt_valid_r | evt_ready);
    drop_s   = gen_s & evt_valid_r & ~evt_ready;
  end

  // Filter FSM: level only toggles after FILTER consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= STABLE;
      qual_r  <= 8'd0;
      level_r <= INITVAL;
    end else begin
      case (state_r)
        STABLE, QUALIFY: begin
          if (toggle_s) begin
            level_r <= ~level_r;
            state_r <= STABLE;
            qual_r  <= 8'd0;
          end else if (sin != level_r) begin
            state_r <= QUALIFY;
            qual_r  <= qual_nxt_s;
          end else begin
            state_r <= STABLE;
            qual_r  <= 8'd0;
          end
        end
        default: begin
          state_r <= STABLE;
          qual_r  <= 8'd0;
        end
      endcase
    end
  end

  // One-entry event buffer; a drop wins over ovf_clr in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_r <= 1'b0;
      evt_rise_r  <= 1'b0;
      evt_ovf_r   <= 1'b0;
    end else begin
      if (load_s) begin
        evt_valid_r <= 1'b1;
        evt_rise_r  <= ~level_r;
      end else if (accept_s) begin
        evt_valid_r <= 1'b0;
      end
      if (drop_s) begin
        evt_ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf_r <= 1'b0;
      end
    end
  end

`ifdef LTZ_EDGE_CATCH_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Accepted-event counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign evt_cnt = cnt_r;
`else
  assign evt_cnt = {CNT_W{1'b0}};
`endif

  assign level     = level_r;
  assign evt_valid = evt_valid_r;
  assign evt_rise  = evt_rise_r;
  assign evt_ovf   = evt_ovf_r;

endmodule
